// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: default sizes, I/Q sample layout, CP-insert FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ofdm_pkg;

  localparam int NFFT_DEF = 64;
  localparam int NCP_DEF  = 16;
  localparam int DW_DEF   = 32;

  // I occupies the upper half, Q the lower half, both two's complement.
  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sample_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_BODY   = 2'd2
  } cp_state_t;

endpackage

// File: rtl/cp_buf_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks, addressed {bank, index}.
// Latency: write lands on the edge; read data appears 1 edge after re, then holds.
// Backpressure: none; rdata only changes on a read, so the caller stalls by withholding re.
module cp_buf_ram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Store each accepted input sample.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; output holds between reads so a stalled sample stays put.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion: buffers NFFT-sample symbols in two banks, replays the last NCP then all NFFT.
// Latency: stb_o rises 2 edges after the last sample of a symbol is accepted (output idle).
// Backpressure: ack_o low while the write bank is still full; output holds dat/stb/cyc/we while ack_i low.
module cp_insert
  import ofdm_pkg::*;
#(
  parameter int NFFT = NFFT_DEF,
  parameter int NCP  = NCP_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dat_i,
  input  logic          we_i,
  input  logic          stb_i,
  input  logic          cyc_i,
  output logic          ack_o,
  output logic [DW-1:0] dat_o,
  output logic          we_o,
  output logic          stb_o,
  output logic          cyc_o,
  input  logic          ack_i
);

  localparam int IW = $clog2(NFFT);
  localparam int CW = $clog2(2 * NFFT) + 1;
  // Prefix starts NCP words before the end; NFFT is a power of two so the
  // read index simply wraps from NFFT-1 into the body at word 0.
  localparam logic [IW-1:0] RD_START = IW'((NFFT - NCP) % NFFT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NFFT - 1);
  localparam logic [CW-1:0] NCP_C    = CW'(NCP);
  localparam logic [CW-1:0] TOT_C    = CW'(NFFT + NCP);

  // Write side
  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic          wr_last;
  logic [1:0]    bank_full;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;

  // Read side
  cp_state_t     state;
  cp_state_t     state_nx;
  logic          rd_bank;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] xfer_cnt;
  logic          rd_en;
  logic          xfer;
  logic          rd_last;
  logic          stb_r;
  logic [DW-1:0] ram_q;

  assign ack_o   = ~rst & cyc_i & stb_i & we_i & ~bank_full[wr_bank];
  assign wr_last = ack_o & (wr_idx == LAST_IDX);

  assign xfer    = stb_r & ack_i;
  assign rd_last = xfer & ((xfer_cnt + CW'(1)) == TOT_C);

  assign set_mask = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = rd_last ? (2'b01 << rd_bank) : 2'b00;

  // Write index and bank advance only on accepted samples; framing is purely by count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (ack_o) begin
      wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank ownership: fill and drain always target different banks, so both updates apply together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and RAM read enable; reads run one ahead of transfers and pause on a stall.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bank_full[rd_bank]) begin
          state_nx = (NCP == 0) ? ST_BODY : ST_PREFIX;
        end
      end
      ST_PREFIX: begin
        rd_en = (rd_cnt != TOT_C) & (~stb_r | ack_i);
        if (xfer && ((xfer_cnt + CW'(1)) == NCP_C)) begin
          state_nx = ST_BODY;
        end
      end
      ST_BODY: begin
        rd_en = (rd_cnt != TOT_C) & (~stb_r | ack_i);
        if (rd_last) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read pointer and issued-read count, re-armed whenever the FSM is idle.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      rd_idx <= RD_START;
      rd_cnt <= '0;
    end else if (rd_en) begin
      rd_idx <= rd_idx + 1'b1;
      rd_cnt <= rd_cnt + CW'(1);
    end
  end

  // Completed-transfer count drives the PREFIX/BODY/IDLE transitions.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      xfer_cnt <= '0;
    end else if (xfer) begin
      xfer_cnt <= xfer_cnt + CW'(1);
    end
  end

  // Read bank flips once its last body sample has gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank <= 1'b0;
    end else if (rd_last) begin
      rd_bank <= ~rd_bank;
    end
  end

  // Strobe follows RAM data validity: set by a read, cleared by a transfer with no refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_r <= 1'b0;
    end else if (rd_en) begin
      stb_r <= 1'b1;
    end else if (ack_i) begin
      stb_r <= 1'b0;
    end
  end

  cp_buf_ram #(
    .DW (DW),
    .AW (IW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ack_o),
    .waddr ({wr_bank, wr_idx}),
    .wdata (dat_i),
    .re    (rd_en),
    .raddr ({rd_bank, rd_idx}),
    .rdata (ram_q)
  );

  assign dat_o = stb_r ? ram_q : '0;
  assign stb_o = stb_r;
  assign we_o  = stb_r;
  assign cyc_o = stb_r;

endmodule
